// File: rtl/world_pkg.sv
// rtl/world_pkg.sv - shared world codes, map geometry and palette
package world_pkg;

   localparam int CELL_LOG2 = 5;
   localparam int MAP_ROWS  = 10;
   localparam int MAP_COLS  = 20;
   localparam int BLINK_BIT = 4;

   typedef enum logic [1:0] {
      ORIENT_NORTH = 2'b00,
      ORIENT_SOUTH = 2'b01,
      ORIENT_EAST  = 2'b10,
      ORIENT_WEST  = 2'b11
   } orient_t;

   localparam logic [2:0] CELL_FLOOR  = 3'd0;
   localparam logic [2:0] CELL_WALL   = 3'd1;
   localparam logic [2:0] CELL_DEBRIS = 3'd2;
   localparam logic [2:0] CELL_MARKER = 3'd7;

   typedef logic [23:0] rgb_t;

   localparam rgb_t COLOR_BLACK       = 24'h000000;
   localparam rgb_t COLOR_ROBOT       = 24'hFFFF00;
   localparam rgb_t COLOR_GRID        = 24'h404040;
   localparam rgb_t COLOR_FLOOR       = 24'h202020;
   localparam rgb_t COLOR_WALL        = 24'h808080;
   localparam rgb_t COLOR_DEBRIS_DIM  = 24'hC06000;
   localparam rgb_t COLOR_DEBRIS_HIGH = 24'hFF8000;
   localparam rgb_t COLOR_MARKER      = 24'h0080FF;
   localparam rgb_t COLOR_UNKNOWN     = 24'hFF00FF;

   function automatic logic in_span(input int v, input int lo, input int hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/map_renderer_if.sv
// rtl/map_renderer_if.sv - world map read port (address out, code back one cycle later)
interface map_renderer_if;

   logic [7:0] map_addr;
   logic [2:0] map_data;

   modport master (output map_addr, input  map_data);
   modport slave  (input  map_addr, output map_data);

endinterface

// File: rtl/robot_sprite.sv
// rtl/robot_sprite.sv - robot body and nose shape within one cell
module robot_sprite
   import world_pkg::*;
#(
   parameter int OFF_W = 5
) (
   input  logic [OFF_W-1:0] off_x,
   input  logic [OFF_W-1:0] off_y,
   input  logic [1:0]       orientation,
   output logic             hit
);

   int   x;
   int   y;
   logic body;
   logic nose;

   always_comb begin
      x    = int'(off_x);
      y    = int'(off_y);
      body = in_span(x, 8, 23) && in_span(y, 8, 23);
      nose = 1'b0;
      case (orient_t'(orientation))
         ORIENT_NORTH: nose = in_span(x, 12, 19) && in_span(y, 2, 7);
         ORIENT_SOUTH: nose = in_span(x, 12, 19) && in_span(y, 24, 29);
         ORIENT_EAST:  nose = in_span(x, 24, 29) && in_span(y, 12, 19);
         ORIENT_WEST:  nose = in_span(x, 2, 7)   && in_span(y, 12, 19);
         default:      nose = 1'b0;
      endcase
      hit = body || nose;
   end

endmodule

// File: rtl/map_renderer.sv
// rtl/map_renderer.sv - per-pixel map colour with robot overlay, 3-cycle aligned RGB and syncs
module map_renderer #(
   parameter int CELL_LOG2 = world_pkg::CELL_LOG2,
   parameter int MAP_ROWS  = world_pkg::MAP_ROWS,
   parameter int MAP_COLS  = world_pkg::MAP_COLS,
   parameter int BLINK_BIT = world_pkg::BLINK_BIT
) (
   input  logic                 clock_50,
   input  logic                 reset_key,
   input  logic [9:0]           pixel_x,
   input  logic [9:0]           pixel_y,
   input  logic                 video_on,
   input  logic                 hsync_in,
   input  logic                 vsync_in,
   input  logic [5:0]           robot_row,
   input  logic [5:0]           robot_column,
   input  logic [2:0]           robot_orientation,
   map_renderer_if.master       map_bus,
   output logic                 vga_hs,
   output logic                 vga_vs,
   output logic [7:0]           vga_r,
   output logic [7:0]           vga_g,
   output logic [7:0]           vga_b
);
   import world_pkg::*;

   localparam int CW = 10 - CELL_LOG2;

   logic [CW-1:0]        cell_row;
   logic [CW-1:0]        cell_col;
   logic                 in_map_c;
   logic [7:0]           addr_c;
   logic                 snap_ok_c;
   logic                 unused_orient_msb;

   logic [CW-1:0]        s1_row, s1_col, s2_row, s2_col;
   logic [CELL_LOG2-1:0] s1_offx, s1_offy, s2_offx, s2_offy;
   logic                 s1_in_map, s2_in_map;
   logic [2:0]           hs_sr, vs_sr;
   logic                 vsync_q;
   logic [7:0]           frame_cnt;
   logic                 snap_valid;
   logic [5:0]           snap_row0, snap_col0;
   logic [1:0]           snap_orient;
   logic                 shape_hit;
   logic                 sprite_hit;
   rgb_t                 pix_c;
   rgb_t                 rgb_q;

   assign cell_row  = pixel_y[9:CELL_LOG2];
   assign cell_col  = pixel_x[9:CELL_LOG2];
   assign in_map_c  = video_on && (cell_row < CW'(MAP_ROWS)) && (cell_col < CW'(MAP_COLS));
   // Map is stored with 1-based row/col, so the first drawn cell lives at address 21.
   assign addr_c    = (8'(cell_row) + 8'd1) * 8'(MAP_COLS) + 8'(cell_col) + 8'd1;
   assign snap_ok_c = (robot_row != 6'd0) && (robot_row <= 6'(MAP_ROWS)) &&
                      (robot_column != 6'd0) && (robot_column <= 6'(MAP_COLS));
   assign unused_orient_msb = robot_orientation[2];

   robot_sprite #(.OFF_W(CELL_LOG2)) u_sprite (
      .off_x       (s2_offx),
      .off_y       (s2_offy),
      .orientation (snap_orient),
      .hit         (shape_hit)
   );

   assign sprite_hit = snap_valid && shape_hit &&
                       (6'(s2_row) == snap_row0) && (6'(s2_col) == snap_col0);

   always_comb begin
      pix_c = COLOR_BLACK;
      if (!s2_in_map)
         pix_c = COLOR_BLACK;
      else if (sprite_hit)
         pix_c = COLOR_ROBOT;
      else if (s2_offx == '0 || s2_offy == '0)
         pix_c = COLOR_GRID;
      else begin
         case (map_bus.map_data)
            CELL_FLOOR:  pix_c = COLOR_FLOOR;
            CELL_WALL:   pix_c = COLOR_WALL;
            CELL_DEBRIS: pix_c = frame_cnt[BLINK_BIT] ? COLOR_DEBRIS_HIGH : COLOR_DEBRIS_DIM;
            CELL_MARKER: pix_c = COLOR_MARKER;
            default:     pix_c = COLOR_UNKNOWN;
         endcase
      end
   end

   always_ff @(posedge clock_50) begin
      if (!reset_key) begin
         s1_row           <= '0;
         s1_col           <= '0;
         s1_offx          <= '0;
         s1_offy          <= '0;
         s1_in_map        <= 1'b0;
         map_bus.map_addr <= 8'd0;
         s2_row           <= '0;
         s2_col           <= '0;
         s2_offx          <= '0;
         s2_offy          <= '0;
         s2_in_map        <= 1'b0;
         rgb_q            <= COLOR_BLACK;
         hs_sr            <= 3'b111;
         vs_sr            <= 3'b111;
         vsync_q          <= 1'b1;
         frame_cnt        <= 8'd0;
         snap_valid       <= 1'b0;
         snap_row0        <= 6'd0;
         snap_col0        <= 6'd0;
         snap_orient      <= 2'b00;
      end else begin
         s1_row           <= cell_row;
         s1_col           <= cell_col;
         s1_offx          <= pixel_x[CELL_LOG2-1:0];
         s1_offy          <= pixel_y[CELL_LOG2-1:0];
         s1_in_map        <= in_map_c;
         map_bus.map_addr <= in_map_c ? addr_c : 8'd0;
         // Second stage only re-times geometry so it lines up with map_data.
         s2_row           <= s1_row;
         s2_col           <= s1_col;
         s2_offx          <= s1_offx;
         s2_offy          <= s1_offy;
         s2_in_map        <= s1_in_map;
         rgb_q            <= pix_c;
         hs_sr            <= {hs_sr[1:0], hsync_in};
         vs_sr            <= {vs_sr[1:0], vsync_in};
         vsync_q          <= vsync_in;
         // Robot position is frozen per frame so the sprite never tears mid-scan.
         if (vsync_q && !vsync_in) begin
            frame_cnt   <= frame_cnt + 8'd1;
            snap_valid  <= snap_ok_c;
            snap_row0   <= robot_row - 6'd1;
            snap_col0   <= robot_column - 6'd1;
            snap_orient <= robot_orientation[1:0];
         end
      end
   end

   assign vga_hs = hs_sr[2];
   assign vga_vs = vs_sr[2];
   assign {vga_r, vga_g, vga_b} = rgb_q;

endmodule
